// File: rtl/stream_mux_rr_pkg.sv
// stream_mux_pkg: shared types and helpers for the stream_mux_rr slice.
//   lock_state_t : packet-lock states (used when STREAM_MUX_PKT_LOCK_EN is defined)
//   rr_pick_t    : result of a round-robin search (found flag + channel index)
//   rr_pick()    : round-robin priority search over up to MAX_CH channels
package stream_mux_pkg;

  localparam int MAX_CH = 16;
  localparam int MAX_CH_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  typedef struct packed {
    logic                found;
    logic [MAX_CH_W-1:0] idx;
  } rr_pick_t;

  // First valid channel searching ptr+1, ptr+2, ... modulo n.
  // Iterates from the farthest candidate down so the nearest hit wins
  // without needing an early exit.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] valid,
                                       input logic [MAX_CH_W-1:0] ptr,
                                       input int unsigned n);
    rr_pick_t    r;
    int unsigned c;
    r = '0;
    for (int unsigned k = n; k >= 1; k--) begin
      c = (int'(ptr) + k) % n;
      if (valid[c]) begin
        r.found = 1'b1;
        r.idx   = c[MAX_CH_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: handshake bundle between N_CH producers, the mux and one consumer.
//   in_valid/in_data/in_ready : producer side, channel i at in_data[i*DATA_W +: DATA_W]
//   out_valid/out_data/out_ch/out_ready : consumer side
//   in_last/out_last : present only when STREAM_MUX_PKT_LOCK_EN is defined
// Modports: slave = mux view, master = producer/consumer (testbench) view.
interface stream_mux_rr_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]        in_valid;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_ready;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [N_CH-1:0]        in_last;
  logic                   out_last;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
`ifdef STREAM_MUX_PKT_LOCK_EN
    , input in_last, output out_last
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
`ifdef STREAM_MUX_PKT_LOCK_EN
    , output in_last, input out_last
`endif
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// rr_arbiter: combinational round-robin priority search (N_CH <= 16).
//   valid : per-channel request vector
//   ptr   : last granted channel; search starts at ptr+1
//   found : at least one request present
//   idx   : granted channel (0 when found=0)
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] valid,
  input  logic [CH_W-1:0] ptr,
  output logic            found,
  output logic [CH_W-1:0] idx
);

  rr_pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_CH'(valid), MAX_CH_W'(ptr), N_CH);
    found = pick.found;
    idx   = CH_W'(pick.idx);
  end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_CH-to-1 valid/ready stream mux with a registered output stage.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   mode       : 0 = fixed select via sel, 1 = round-robin over valid channels
//   sel        : channel picked in fixed mode (ignored if >= N_CH)
//   bus        : stream_mux_rr_if.slave (inputs, in_ready, registered outputs)
// Optional: STREAM_MUX_PKT_LOCK_EN adds in_last/out_last and holds the grant
// on one channel until the beat carrying in_last has transferred.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int CH_W   = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [CH_W-1:0] sel,
  stream_mux_rr_if.slave  bus
);

  // Valid vector widened to the full selector range so an out-of-range sel
  // reads a zero instead of indexing past the vector.
  localparam int SEL_SPAN = 1 << CH_W;

  logic [SEL_SPAN-1:0] valid_ext;
  logic [CH_W-1:0]     rr_ptr;
  logic                rr_found;
  logic [CH_W-1:0]     rr_idx;
  logic                fixed_hit;
  logic                found;
  logic [CH_W-1:0]     grant;
  logic                load;
  logic                xfer;
  logic                rr_upd;
  logic [DATA_W-1:0]   beat;

  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [CH_W-1:0]     out_ch_q;

`ifdef STREAM_MUX_PKT_LOCK_EN
  logic [SEL_SPAN-1:0] last_ext;
  lock_state_t         lock_state;
  logic [CH_W-1:0]     lock_ch;
  logic                out_last_q;
  logic                beat_last;
`endif

  assign valid_ext = SEL_SPAN'(bus.in_valid);

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .valid (bus.in_valid),
    .ptr   (rr_ptr),
    .found (rr_found),
    .idx   (rr_idx)
  );

  always_comb begin
    fixed_hit = (32'(sel) < N_CH) && valid_ext[sel];
    if (mode) begin
      found = rr_found;
      grant = rr_idx;
    end else begin
      found = fixed_hit;
      grant = fixed_hit ? sel : '0;
    end
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_state == LOCKED) begin
      found = valid_ext[lock_ch];
      grant = lock_ch;
    end
`endif
  end

  assign load = !out_valid_q || bus.out_ready;
  assign xfer = found && load;
  assign beat = bus.in_data[int'(grant)*DATA_W +: DATA_W];

  assign bus.in_ready = {{(N_CH-1){1'b0}}, xfer} << grant;

`ifdef STREAM_MUX_PKT_LOCK_EN
  assign last_ext  = SEL_SPAN'(bus.in_last);
  assign beat_last = last_ext[grant];
  // Pointer only moves once a whole packet (or a single-beat one) is done,
  // so the channel after the finished packet gets the next turn.
  assign rr_upd    = mode && xfer && beat_last;
`else
  assign rr_upd    = mode && xfer;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= CH_W'(N_CH - 1);
    end else begin
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat;
        out_ch_q    <= grant;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (rr_upd) begin
        rr_ptr <= grant;
      end
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= IDLE;
      lock_ch    <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (xfer) begin
        out_last_q <= beat_last;
      end
      case (lock_state)
        IDLE: begin
          if (xfer && !beat_last) begin
            lock_state <= LOCKED;
            lock_ch    <= grant;
          end
        end
        LOCKED: begin
          if (xfer && beat_last) begin
            lock_state <= IDLE;
          end
        end
        default: lock_state <= IDLE;
      endcase
    end
  end

  assign bus.out_last = out_last_q;
`endif

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed + randomized bench for stream_mux_rr (N_CH=4, DATA_W=8)
// against a behavioural model of the grant/output rules.
// Lock scenario is compiled in when STREAM_MUX_PKT_LOCK_EN is defined.
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] sel = '0;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic       m_ov;
  logic [7:0] m_od;
  logic [1:0] m_och;
  int         m_last;
  logic       m_ol;
  logic       m_locked;
  int         m_lch;

  stream_mux_rr_if #(.N_CH(N), .DATA_W(W)) bus ();

  stream_mux_rr #(.N_CH(N), .DATA_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .sel   (sel),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov = 1'b0; m_od = '0; m_och = '0; m_last = N - 1;
    m_ol = 1'b0; m_locked = 1'b0; m_lch = 0;
  endtask

  // Grant from the behavioural rules; -1 means nobody is granted.
  function automatic int model_grant(input logic md, input int sl, input logic [3:0] v);
    if (m_locked) return v[m_lch] ? m_lch : -1;
    if (!md) return (sl < N && v[sl]) ? sl : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  // One clock: drive inputs, check in_ready mid-cycle, check outputs after the edge.
  task automatic cycle(input logic md, input logic [1:0] sl, input logic [3:0] v,
                       input logic [31:0] d, input logic ordy, input logic [3:0] lst);
    int         g;
    logic       ld;
    logic [3:0] exp_rdy;
    logic [31:0] dd;
    mode = md; sel = sl; bus.in_valid = v; bus.in_data = d; bus.out_ready = ordy;
`ifdef STREAM_MUX_PKT_LOCK_EN
    bus.in_last = lst;
`endif
    @(negedge clk);
    g = model_grant(md, int'(sl), v);
    ld = !m_ov || ordy;
    exp_rdy = (g >= 0 && ld) ? 4'(1 << g) : 4'b0000;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (g >= 0 && ld) begin
      dd = d >> (8 * g);
      m_ov = 1'b1; m_od = dd[7:0]; m_och = 2'(g); m_ol = lst[g];
`ifdef STREAM_MUX_PKT_LOCK_EN
      if (md && lst[g]) m_last = g;
      if (!m_locked && !lst[g]) begin m_locked = 1'b1; m_lch = g; end
      else if (m_locked && lst[g]) m_locked = 1'b0;
`else
      if (md) m_last = g;
`endif
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
    chk("out_data", 32'(bus.out_data), 32'(m_od));
    chk("out_ch", 32'(bus.out_ch), 32'(m_och));
`ifdef STREAM_MUX_PKT_LOCK_EN
    chk("out_last", 32'(bus.out_last), 32'(m_ol));
`endif
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic mid_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("async_rst_ch", 32'(bus.out_ch), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int         seq[6];
    int         alt[4];
    logic [7:0] hold;
    logic [31:0] d;

    model_reset();
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    bus.in_last = '1;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b1;

    // Fixed select of channel 2
    cycle(1'b0, 2'd2, 4'b0100, 32'h00A5_0000, 1'b1, 4'b1111);
    chk("fix_valid", 32'(bus.out_valid), 32'd1);
    chk("fix_data", 32'(bus.out_data), 32'hA5);
    chk("fix_ch", 32'(bus.out_ch), 32'd2);

    // Round-robin fairness with all channels valid
    seq = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 2'd0, 4'b1111, 32'h4433_2211 + 32'(i), 1'b1, 4'b1111);
      chk("rr_seq", 32'(bus.out_ch), 32'(seq[i]));
    end

    mid_reset();

    // Sparse requests alternate
    alt = '{1, 3, 1, 3};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'd0, 4'b1010, $urandom, 1'b1, 4'b1111);
      chk("rr_alt", 32'(bus.out_ch), 32'(alt[i]));
    end

    // Backpressure: data held, no accept, then no bubble on release
    cycle(1'b1, 2'd0, 4'b1111, 32'hDDCC_BBAA, 1'b1, 4'b1111);
    hold = bus.out_data;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'd0, 4'b1111, $urandom, 1'b0, 4'b1111);
      chk("bp_hold", 32'(bus.out_data), 32'(hold));
    end
    cycle(1'b1, 2'd0, 4'b1111, 32'h4433_2211, 1'b1, 4'b1111);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_release_ch", 32'(bus.out_ch), 32'd1);

    // Fixed select of an idle channel: pending beat drains, nothing loads
    cycle(1'b0, 2'd1, 4'b1101, $urandom, 1'b1, 4'b1111);
    chk("nogrant_drain", 32'(bus.out_valid), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom),
            d, 1'($urandom_range(0, 3) != 0), 4'($urandom));
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    mid_reset();
    // Single beat on channel 1 moves the pointer so channel 2 is next
    cycle(1'b1, 2'd0, 4'b0010, 32'h0000_1100, 1'b1, 4'b1111);
    seq = '{2, 2, 2, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'd0, 4'b0101, 32'h0020_0000 + 32'(i) + (32'(i) << 16),
            1'b1, (i == 2) ? 4'b0101 : 4'b0001);
      chk("lock_seq", 32'(bus.out_ch), 32'(seq[i]));
      chk("lock_last", 32'(bus.out_last), (i == 2 || i == 3) ? 32'd1 : 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
